// File: rtl/bam_integrated_pkg.sv
// Shared constants, Booth digit type and recoding helpers for the registered Booth multiplier.
// Purely declarative: no latency, no flow control.
package bam_integrated_pkg;

  localparam int WIDTH   = 32;
  localparam int NDIGITS = WIDTH / 2;
  localparam int PWIDTH  = 2 * WIDTH;
  // Two guard bits so that +/-2A of the most negative operand stays exact.
  localparam int PPWIDTH = WIDTH + 2;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Radix-4 recoding of the overlapping triple {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  function automatic logic [PPWIDTH-1:0] booth_pp(input booth_digit_t d,
                                                  input logic [WIDTH-1:0] a);
    logic [PPWIDTH-1:0] ax;
    logic [PPWIDTH-1:0] pp;
    ax = {{2{a[WIDTH-1]}}, a};
    case (d)
      POS1:    pp = ax;
      POS2:    pp = ax << 1;
      NEG1:    pp = -ax;
      NEG2:    pp = -(ax << 1);
      default: pp = '0;
    endcase
    return pp;
  endfunction

endpackage

// File: rtl/bam_integrated_booth_mult_core.sv
// Combinational 32x32 signed radix-4 Booth multiplier: recoder, partial products, adder tree.
// Zero latency, no flow control; output follows a/b combinationally.
module booth_mult_core
  import bam_integrated_pkg::*;
(
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [PWIDTH-1:0] p
);

  logic [WIDTH:0]        bx;
  booth_digit_t          digit [NDIGITS];
  logic [PPWIDTH-1:0]    pp    [NDIGITS];
  logic [PWIDTH-1:0]     row   [NDIGITS];
  logic [PWIDTH-1:0]     s1    [NDIGITS/2];
  logic [PWIDTH-1:0]     s2    [NDIGITS/4];
  logic [PWIDTH-1:0]     s3    [NDIGITS/8];

  assign bx = {b, 1'b0};

  always_comb begin
    for (int i = 0; i < NDIGITS; i++) begin
      digit[i] = booth_recode(bx[2*i +: 3]);
      pp[i]    = booth_pp(digit[i], a);
      row[i]   = {{(PWIDTH-PPWIDTH){pp[i][PPWIDTH-1]}}, pp[i]} << (2*i);
    end
    for (int i = 0; i < NDIGITS/2; i++) s1[i] = row[2*i] + row[2*i+1];
    for (int i = 0; i < NDIGITS/4; i++) s2[i] = s1[2*i] + s1[2*i+1];
    for (int i = 0; i < NDIGITS/8; i++) s3[i] = s2[2*i] + s2[2*i+1];
    // Sum wraps modulo 2^64, which is exactly the signed product.
    p = s3[0] + s3[1];
  end

endmodule

// File: rtl/bam_integrated.sv
// Registered signed multiplier: operand registers A/B feed the Booth core, product register captures it.
// Latency 2 edges minimum (load, then enableOut); no handshake, each stage enabled by the controller.
module bam_integrated
  import bam_integrated_pkg::*;
(
  input  logic              clk,
  input  logic              resetA,
  input  logic              resetB,
  input  logic              resetOut,
  input  logic [WIDTH-1:0]  Multiplicand,
  input  logic [WIDTH-1:0]  Multiplier,
  input  logic              enableA,
  input  logic              enableB,
  input  logic              enableOut,
  output logic [PWIDTH-1:0] Product
);

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [PWIDTH-1:0] booth_p;

  always_ff @(posedge clk) begin
    if (resetA)       a_q <= '0;
    else if (enableA) a_q <= Multiplicand;
  end

  always_ff @(posedge clk) begin
    if (resetB)       b_q <= '0;
    else if (enableB) b_q <= Multiplier;
  end

  booth_mult_core u_core (
    .a (a_q),
    .b (b_q),
    .p (booth_p)
  );

  always_ff @(posedge clk) begin
    if (resetOut)       Product <= '0;
    else if (enableOut) Product <= booth_p;
  end

endmodule

// File: tb/tb_bam_integrated.sv
// Directed and randomized checks of bam_integrated against an arithmetic reference model.
module tb_bam_integrated;

  logic        clk = 1'b0;
  logic        resetA = 1'b0, resetB = 1'b0, resetOut = 1'b0;
  logic [31:0] Multiplicand = '0, Multiplier = '0;
  logic        enableA = 1'b0, enableB = 1'b0, enableOut = 1'b0;
  logic [63:0] Product;

  int checks = 0;
  int errors = 0;

  logic [31:0] ma, mb;
  logic [63:0] mp;

  bam_integrated dut (
    .clk          (clk),
    .resetA       (resetA),
    .resetB       (resetB),
    .resetOut     (resetOut),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .enableA      (enableA),
    .enableB      (enableB),
    .enableOut    (enableOut),
    .Product      (Product)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic check(input string tag, input logic [63:0] exp);
    checks++;
    assert (Product === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, Product, exp);
    end
  endtask

  // One clock edge with the given controls; the model is updated with register semantics
  // (product uses the operands held before this edge) and compared after the edge.
  task automatic cycle(input logic ra, input logic rb, input logic ro,
                       input logic ea, input logic eb, input logic eo,
                       input logic [31:0] mc, input logic [31:0] ml, input string tag);
    logic [63:0] np;
    @(negedge clk);
    resetA = ra; resetB = rb; resetOut = ro;
    enableA = ea; enableB = eb; enableOut = eo;
    Multiplicand = mc; Multiplier = ml;
    @(posedge clk);
    np = ro ? 64'd0 : (eo ? smul(ma, mb) : mp);
    if (ra) ma = '0; else if (ea) ma = mc;
    if (rb) mb = '0; else if (eb) mb = ml;
    mp = np;
    #1;
    check(tag, mp);
  endtask

  task automatic vec(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp,
                     input string tag);
    cycle(0, 0, 0, 1, 1, 0, x, y, {tag, "_load"});
    cycle(0, 0, 0, 0, 0, 1, $urandom, $urandom, {tag, "_model"});
    check({tag, "_const"}, exp);
  endtask

  initial begin
    ma = '0; mb = '0; mp = '0;

    cycle(1, 1, 1, 0, 0, 0, 32'h0, 32'h0, "reset");
    cycle(0, 0, 0, 0, 0, 1, 32'h1234, 32'h5678, "zero_ops");

    vec(32'h00087234, 32'h00000348, 64'h000000001BB6BAA0, "pos_pos");
    vec(32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564, "pos_neg");
    vec(32'hFFFFFEFD, 32'h00087234, 64'hFFFFFFFFF7747564, "neg_pos");
    vec(32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609, "neg_neg");
    vec(32'hB887CAAF, 32'h50647236, 64'hE98E647F4142AEEA, "big1");
    vec(32'h50647236, 32'hB887CAAF, 64'hE98E647F4142AEEA, "big1_swap");
    vec(32'h50647236, 32'h50612336, 64'h193DE4CED7437964, "big2");
    vec(32'hB887CAAF, 32'h887CAAF3, 64'h215D8B0A7A419A1D, "big3");
    vec(32'h00000001, 32'h50647236, 64'h0000000050647236, "ident_a");
    vec(32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF, "ident_b");
    vec(32'h00000000, 32'hB887CAAF, 64'h0, "zero_a");
    vec(32'h50647236, 32'h00000000, 64'h0, "zero_b");
    vec(32'h80000000, 32'h80000000, 64'h4000000000000000, "minneg_sq");
    vec(32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, "minneg_maxpos");

    // Product holds while operands reload with enableOut low.
    cycle(0, 0, 0, 1, 1, 0, 32'h00000003, 32'h00000005, "hold_reload");
    cycle(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D, "hold_inputs");
    check("hold_const", 64'hC000000080000000);
    // Simultaneous load and capture picks up the old operands.
    cycle(0, 0, 0, 1, 1, 1, 32'h00000007, 32'h00000009, "same_edge_old");
    check("same_edge_const", 64'd15);
    cycle(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "same_edge_new");
    check("same_edge_new_const", 64'd63);
    // resetOut wins over enableOut.
    cycle(0, 0, 1, 0, 0, 1, 32'h0, 32'h0, "resetout_prio");
    check("resetout_const", 64'd0);
    cycle(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "after_resetout");
    // resetA alone clears only A; product becomes zero.
    cycle(1, 0, 0, 1, 0, 0, 32'h11111111, 32'h0, "reseta_prio");
    cycle(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "reseta_product");
    check("reseta_const", 64'd0);
    cycle(0, 0, 0, 1, 0, 1, 32'h00000002, 32'h0, "b_kept_load");
    cycle(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "b_kept");
    check("b_kept_const", 64'd18);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      if (($urandom % 8) == 0) x = (($urandom % 2) == 0) ? 32'h80000000 : 32'h7FFFFFFF;
      if (($urandom % 8) == 0) y = (($urandom % 2) == 0) ? 32'h80000000 : 32'hFFFFFFFF;
      cycle(($urandom % 16) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0,
            ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 3) != 0,
            x, y, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
